// File: rtl/layer_input_streamer.sv
// Packs NUM_CH channel words into one pixel beat and walks an IMG_SIZE x IMG_SIZE frame per start.
// Pixel beat appears 1 cycle after its last word; upstream is stalled only outside a frame (no output backpressure).
module layer_input_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 16,
  parameter int IMG_SIZE    = 208,
  parameter int COORD_WIDTH = 8
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic [COORD_WIDTH-1:0]       row_out,
  output logic [COORD_WIDTH-1:0]       col_out,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state, state_nxt;
  logic [CH_W-1:0]              ch_cnt;
  logic [COORD_WIDTH-1:0]       row_cnt, col_cnt;
  logic [NUM_CH*DATA_WIDTH-1:0] pack, pack_nxt;
  logic                         xfer, last_ch, last_col, last_row, pix_done, frame_end;

  assign xfer      = in_valid && in_ready;
  assign last_ch   = (ch_cnt == CH_W'(NUM_CH - 1));
  assign last_col  = (col_cnt == COORD_WIDTH'(IMG_SIZE - 1));
  assign last_row  = (row_cnt == COORD_WIDTH'(IMG_SIZE - 1));
  assign pix_done  = xfer && last_ch;
  assign frame_end = pix_done && last_row && last_col;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Current pack with this cycle's word merged in, so the completing word reaches data_out directly.
  always_comb begin
    pack_nxt = pack;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_cnt == CH_W'(c)) begin
        pack_nxt[DATA_WIDTH*c +: DATA_WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ch_cnt  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      pack    <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        ch_cnt  <= '0;
        row_cnt <= '0;
        col_cnt <= '0;
      end
    end else if (xfer) begin
      pack <= pack_nxt;
      if (last_ch) begin
        ch_cnt <= '0;
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Pixel outputs hold between strobes; only the strobes are cleared every cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_out   <= '0;
      row_out    <= '0;
      col_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= pix_done;
      frame_done <= frame_end;
      if (pix_done) begin
        data_out <= pack_nxt;
        row_out  <= row_cnt;
        col_out  <= col_cnt;
      end
    end
  end

endmodule

// File: tb/tb_layer_input_streamer.sv
// Directed bench: full-size streamer for pixel packing and stalls, a 4x4 two-channel one for frames and reset.
module tb_layer_input_streamer;

  logic         Clk;
  logic         Rst;
  logic         start_a, start_b;
  logic [31:0]  in_data_a, in_data_b;
  logic         in_valid_a, in_valid_b;
  logic         in_ready_a, in_ready_b;
  logic [511:0] data_out_a;
  logic [63:0]  data_out_b;
  logic         valid_out_a, valid_out_b;
  logic [7:0]   row_out_a, col_out_a, row_out_b, col_out_b;
  logic         busy_a, busy_b;
  logic         frame_done_a, frame_done_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  layer_input_streamer #(.DATA_WIDTH(32), .NUM_CH(16), .IMG_SIZE(208), .COORD_WIDTH(8)) dut_a (
    .Clk(Clk), .Rst(Rst), .start(start_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .data_out(data_out_a), .valid_out(valid_out_a),
    .row_out(row_out_a), .col_out(col_out_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  layer_input_streamer #(.DATA_WIDTH(32), .NUM_CH(2), .IMG_SIZE(4), .COORD_WIDTH(8)) dut_b (
    .Clk(Clk), .Rst(Rst), .start(start_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .data_out(data_out_b), .valid_out(valid_out_b),
    .row_out(row_out_b), .col_out(col_out_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Feeds words 0..15 into dut_a, optionally idling after one word; returns strobe count and cycles to strobe.
  task automatic feed_pixel_a(input int stall_after, input int stall_len,
                              output int nvalid, output int lat);
    int t0;
    t0     = cyc;
    nvalid = 0;
    lat    = -1;
    for (int i = 0; i < 16; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 32'(i);
      tick();
      if (valid_out_a) begin nvalid++; lat = cyc - t0; end
      if (i == stall_after) begin
        in_valid_a = 1'b0;
        in_data_a  = 32'hBADBAD00;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          if (valid_out_a) begin nvalid++; lat = cyc - t0; end
        end
      end
    end
    in_valid_a = 1'b0;
  endtask

  initial begin
    logic [511:0] exp_a;
    logic [63:0]  exp_b;
    int nv0, lat0, nv1, lat1, p;

    Rst        = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    in_valid_a = 1'b1;
    in_data_a  = 32'hDEADBEEF;
    in_valid_b = 1'b1;
    in_data_b  = 32'h12345678;
    #1;
    check("rst_in_ready", in_ready_a, 0);
    check("rst_valid", valid_out_a, 0);
    check("rst_data", data_out_a, 0);
    tick();
    tick();
    Rst = 1'b0;

    // Idle with in_valid high and no start: nothing moves.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_in_ready", in_ready_a, 0);
      check("idle_busy", busy_a, 0);
      check("idle_valid", valid_out_a, 0);
      check("idle_frame_done", frame_done_a, 0);
      check("idle_data", data_out_a, 0);
      check("idle_rowcol", {row_out_a, col_out_a}, 0);
      check("idle_b_valid", valid_out_b, 0);
    end

    exp_a = '0;
    for (int c = 0; c < 16; c++) exp_a[32*c +: 32] = 32'(c);

    // Single pixel, no stalls.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_busy", busy_a, 1);
    check("a_in_ready", in_ready_a, 1);
    feed_pixel_a(-1, 0, nv0, lat0);
    check("a_pix0_valid_now", valid_out_a, 1);
    check("a_pix0_lo", data_out_a[31:0], 32'h0);
    check("a_pix0_hi", data_out_a[511:480], 32'h0000000F);
    check("a_pix0_data", data_out_a, exp_a);
    check("a_pix0_row", row_out_a, 0);
    check("a_pix0_col", col_out_a, 0);
    check("a_pix0_fd", frame_done_a, 0);
    tick();
    check("a_pix0_strobe_end", valid_out_a, 0);
    check("a_pix0_hold", data_out_a, exp_a);
    check("a_pix0_count", nv0, 1);
    check("a_pix0_lat", lat0, 16);

    // Same words, 3 idle cycles after word 7.
    feed_pixel_a(7, 3, nv1, lat1);
    check("a_pix1_valid_now", valid_out_a, 1);
    check("a_pix1_data", data_out_a, exp_a);
    check("a_pix1_row", row_out_a, 0);
    check("a_pix1_col", col_out_a, 1);
    check("a_pix1_count", nv1, 1);
    check("a_pix1_lat_delta", lat1 - lat0, 3);

    // Full 4x4 frame on dut_b, words 0x0B000000+k.
    in_valid_b = 1'b0;
    start_b    = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_busy", busy_b, 1);
    for (int j = 1; j <= 32; j++) begin
      in_valid_b = 1'b1;
      in_data_b  = 32'h0B000000 + 32'(j - 1);
      tick();
      if (j % 2 == 0) begin
        p     = j / 2 - 1;
        exp_b = {32'h0B000000 + 32'(2 * p + 1), 32'h0B000000 + 32'(2 * p)};
        check("b_f1_valid", valid_out_b, 1);
        check("b_f1_row", row_out_b, 8'(p / 4));
        check("b_f1_col", col_out_b, 8'(p % 4));
        check("b_f1_data", data_out_b, exp_b);
        check("b_f1_fd", frame_done_b, (p == 15) ? 1 : 0);
      end else begin
        check("b_f1_valid_gap", valid_out_b, 0);
        check("b_f1_fd_gap", frame_done_b, 0);
      end
    end
    check("b_f1_end_ready", in_ready_b, 0);
    check("b_f1_end_busy", busy_b, 0);

    // Start in the frame_done cycle; the word offered alongside it is not taken.
    start_b    = 1'b1;
    in_data_b  = 32'hFFFFFFFF;
    tick();
    start_b = 1'b0;
    check("b_f2_busy", busy_b, 1);
    check("b_f2_ready", in_ready_b, 1);
    check("b_f2_no_valid", valid_out_b, 0);
    for (int k = 0; k < 4; k++) begin
      in_data_b = 32'hC0000000 + 32'(k);
      start_b   = (k == 2);
      tick();
      start_b = 1'b0;
      if (k == 1) begin
        check("b_f2_p0_valid", valid_out_b, 1);
        check("b_f2_p0_rowcol", {row_out_b, col_out_b}, 16'h0000);
        check("b_f2_p0_data", data_out_b, 64'hC0000001_C0000000);
      end
    end
    check("b_f2_p1_valid", valid_out_b, 1);
    check("b_f2_p1_rowcol", {row_out_b, col_out_b}, 16'h0001);
    check("b_f2_p1_data", data_out_b, 64'hC0000003_C0000002);

    // Words 4..8: ninth word leaves a half-filled pixel, then reset mid-frame.
    for (int k = 4; k < 9; k++) begin
      in_data_b = 32'hC0000000 + 32'(k);
      tick();
    end
    check("b_pre_rst_col", col_out_b, 3);
    in_valid_b = 1'b0;
    Rst = 1'b1;
    #1;
    check("b_rst_valid", valid_out_b, 0);
    check("b_rst_busy", busy_b, 0);
    check("b_rst_ready", in_ready_b, 0);
    check("b_rst_data", data_out_b, 0);
    tick();
    Rst     = 1'b0;
    start_b = 1'b1;
    tick();
    start_b    = 1'b0;
    in_valid_b = 1'b1;
    in_data_b  = 32'hAAAAAAAA;
    tick();
    check("b_post_rst_w0_valid", valid_out_b, 0);
    in_data_b = 32'h55555555;
    tick();
    in_valid_b = 1'b0;
    check("b_post_rst_valid", valid_out_b, 1);
    check("b_post_rst_data", data_out_b, 64'h55555555_AAAAAAAA);
    check("b_post_rst_row", row_out_b, 0);
    check("b_post_rst_col", col_out_b, 0);
    tick();
    check("b_post_rst_strobe_end", valid_out_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_input_streamer.md
Name: layer_input_streamer

Overview:
- Producer side of the feature-map stream that drives a layer's packed `data_in`/`valid_in` interface.
- Accepts one 32-bit float channel word per handshake from an upstream memory reader.
- Packs NUM_CH consecutive words into one NUM_CH*DATA_WIDTH-bit pixel beat and emits one beat per pixel in raster order, with a one-cycle `valid_out` strobe.
- Counts one full IMG_SIZE x IMG_SIZE frame per `start` and flags completion.

Parameters:
- DATA_WIDTH, 32, width of one channel word (IEEE-754 single).
- NUM_CH, 16, channels packed per pixel beat.
- IMG_SIZE, 208, feature-map width and height in pixels.
- COORD_WIDTH, 8, width of the row/column counters; must satisfy 2^COORD_WIDTH > IMG_SIZE-1.

Ports:
- Clk  input  1  clock; all state on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle frame start request; honoured only in IDLE.
- in_data  input  DATA_WIDTH  channel word from upstream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  streamer accepts a word; a transfer occurs when in_valid && in_ready.
- data_out  output  NUM_CH*DATA_WIDTH  packed pixel; channel c occupies bits [DATA_WIDTH*c+DATA_WIDTH-1 : DATA_WIDTH*c].
- valid_out  output  1  one-cycle strobe; data_out holds a complete pixel.
- row_out  output  COORD_WIDTH  row of the pixel on data_out.
- col_out  output  COORD_WIDTH  column of the pixel on data_out.
- busy  output  1  high while in STREAM.
- frame_done  output  1  one-cycle pulse coincident with valid_out of pixel (IMG_SIZE-1, IMG_SIZE-1).

Behaviour:
- Reset values: all outputs 0, including data_out, row_out, col_out and in_ready. FSM resets to IDLE, all counters to 0, pack register to 0.
- FSM states:
  - IDLE: in_ready=0, busy=0. start=1 -> STREAM; clear ch_cnt, row_cnt and col_cnt.
  - STREAM: in_ready=1, busy=1. Each transfer writes in_data into pack lane ch_cnt and increments ch_cnt.
  - Completing a pixel: the transfer with ch_cnt==NUM_CH-1 also does the following.
    - Next cycle: data_out = full pack (including this word), valid_out=1, row_out/col_out = current row_cnt/col_cnt.
    - ch_cnt wraps to 0.
    - col_cnt increments. At IMG_SIZE-1, col_cnt wraps to 0 and row_cnt increments.
  - Last pixel: the completing transfer at row_cnt==IMG_SIZE-1 and col_cnt==IMG_SIZE-1 moves the FSM to IDLE in the same edge. in_ready is low from the next cycle. frame_done=1 together with that pixel's valid_out.
- Latency: 1 cycle from the last channel's transfer to valid_out. Minimum pixel period is NUM_CH cycles; there is no output backpressure.
- in_valid low in STREAM: no state change, partial pack retained indefinitely.
- data_out, row_out and col_out hold their last values while valid_out=0. valid_out is never high on two consecutive cycles when NUM_CH>1.
- start while in STREAM is ignored.
- start in the cycle the final valid_out is asserted is honoured (FSM already IDLE). This gives back-to-back frames with a one-cycle gap.
- in_data and in_valid in IDLE are ignored. No transfer occurs, since in_ready=0.
- Rst asserted mid-frame: immediate return to IDLE, partial pixel discarded, valid_out and frame_done forced low. A following start begins at pixel (0,0), channel 0.
- Counters are unsigned. row_cnt never exceeds IMG_SIZE-1.

Test Plan:
- Reset/idle: assert Rst, drive in_valid=1 without start -> in_ready, valid_out, busy, frame_done and data_out remain 0; no outputs change.
- Single pixel packing (IMG_SIZE=208): start, feed words 32'h00000000..32'h0000000F on 16 consecutive cycles -> exactly one valid_out, 1 cycle after the 16th transfer. data_out[31:0]=0, data_out[511:480]=32'h0000000F, row_out=0, col_out=0.
- Stall tolerance: same 16 words with in_valid low for 3 cycles after word 7 -> identical data_out; valid_out occurs 3 cycles later than in the unstalled case.
- Full frame (IMG_SIZE=4, NUM_CH=2): start, stream 32 words continuously -> 16 valid_out strobes every 2 cycles with (row,col) sequence (0,0),(0,1)..(0,3),(1,0)..(3,3). frame_done high only on the 16th strobe. in_ready low and busy=0 one cycle after the 32nd transfer.
- Back-to-back frames: start asserted in the frame_done cycle -> second frame starts at (0,0). Extra start pulses mid-frame have no effect on the counters.
- Reset mid-frame (IMG_SIZE=4, NUM_CH=2): assert Rst after 9 words, then start and send 2 words 32'hAAAAAAAA, 32'h55555555 -> first valid_out has data_out={32'h55555555,32'hAAAAAAAA}, row_out=0, col_out=0.
